// File: rtl/axi_delay_multi_ctrl.sv
// Multi-channel IDELAYE3/ODELAYE3 VAR_LOAD tap controller behind a native register port.
// Sequences EN_VTC low -> settle -> LOAD (direct or +/-1 ramp steps) -> gap -> EN_VTC high.
module axi_delay_multi_ctrl #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned TAP_WIDTH         = 9,
    parameter int unsigned NATIVE_ADDR_WIDTH = 5,
    parameter int unsigned NATIVE_DATA_WIDTH = 9,
    parameter int unsigned VTC_SETTLE        = 10,
    parameter int unsigned LOAD_GAP          = 4
) (
    input  logic                            REFCLK,
    input  logic                            REFCLK_RESET,
    input  logic                            NATIVE_EN,
    input  logic                            NATIVE_WR,
    input  logic [NATIVE_ADDR_WIDTH-1:0]    NATIVE_ADDR,
    input  logic [NATIVE_DATA_WIDTH-1:0]    NATIVE_DATA_IN,
    output logic [NATIVE_DATA_WIDTH-1:0]    NATIVE_DATA_OUT,
    output logic                            NATIVE_READY,
    input  logic                            DLY_RDY,
    output logic [NUM_CH*TAP_WIDTH-1:0]     DLY_CNTVALUEIN,
    output logic [NUM_CH-1:0]               DLY_LOAD,
    output logic [NUM_CH-1:0]               DLY_EN_VTC
);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_MAX = (VTC_SETTLE > LOAD_GAP) ? VTC_SETTLE : LOAD_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VTC_OFF,
        ST_LOAD,
        ST_GAP,
        ST_VTC_ON
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [TAP_WIDTH-1:0]           target_q, target_d;
    logic [TAP_WIDTH-1:0]           cur_q [NUM_CH];
    logic [TAP_WIDTH-1:0]           cur_d [NUM_CH];
    logic                           ramp_q, ramp_d;
    logic                           ovr_q, ovr_d;
    logic                           ready_q, ready_d;
    logic [NATIVE_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]              load_q, load_d;
    logic [NUM_CH-1:0]              vtc_q, vtc_d;

    logic                           addr_is_tap;
    logic                           addr_is_ctrl;
    logic [CH_W-1:0]                addr_ch;
    logic [TAP_WIDTH-1:0]           wr_tap;
    logic [TAP_WIDTH-1:0]           addr_tap;
    logic [TAP_WIDTH-1:0]           sel_tap;
    logic [TAP_WIDTH-1:0]           next_tap;
    logic                           busy;

    // Address decode and the tap value the next LOAD should apply
    always_comb begin
        addr_is_tap  = NATIVE_ADDR <  NATIVE_ADDR_WIDTH'(NUM_CH);
        addr_is_ctrl = NATIVE_ADDR == NATIVE_ADDR_WIDTH'(NUM_CH);
        addr_ch      = CH_W'(NATIVE_ADDR);
        wr_tap       = TAP_WIDTH'(NATIVE_DATA_IN);
        addr_tap     = cur_q[addr_ch];
        sel_tap      = cur_q[ch_q];
        busy         = (state_q != ST_IDLE);
        if (!ramp_q)
            next_tap = target_q;
        else if (target_q > sel_tap)
            next_tap = sel_tap + TAP_WIDTH'(1);
        else
            next_tap = sel_tap - TAP_WIDTH'(1);
    end

    // Next-state, register-port handling and registered output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        target_d = target_q;
        cur_d    = cur_q;
        ramp_d   = ramp_q;
        ovr_d    = ovr_q;
        ready_d  = 1'b0;
        rdata_d  = '0;
        load_d   = '0;
        vtc_d    = '1;

        case (state_q)
            ST_IDLE: begin
                if (NATIVE_EN) begin
                    if (addr_is_tap && NATIVE_WR && (wr_tap != addr_tap)) begin
                        ch_d     = addr_ch;
                        target_d = wr_tap;
                        cnt_d    = '0;
                        state_d  = ST_VTC_OFF;
                    end else begin
                        ready_d = 1'b1;
                        if (addr_is_tap && !NATIVE_WR) begin
                            rdata_d = NATIVE_DATA_WIDTH'(addr_tap);
                        end else if (addr_is_ctrl) begin
                            if (NATIVE_WR) begin
                                ramp_d = NATIVE_DATA_IN[0];
                                if (NATIVE_DATA_IN[3])
                                    ovr_d = 1'b0;
                            end else begin
                                rdata_d = NATIVE_DATA_WIDTH'({ovr_q, DLY_RDY, busy, ramp_q});
                            end
                        end
                    end
                end
            end
            ST_VTC_OFF: begin
                vtc_d[ch_q] = 1'b0;
                if (DLY_RDY) begin
                    if (cnt_q == CNT_W'(VTC_SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                vtc_d[ch_q]  = 1'b0;
                load_d[ch_q] = 1'b1;
                cur_d[ch_q]  = next_tap;
                cnt_d        = '0;
                state_d      = ST_GAP;
            end
            ST_GAP: begin
                vtc_d[ch_q] = 1'b0;
                if (cnt_q == CNT_W'(LOAD_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = (sel_tap != target_q) ? ST_LOAD : ST_VTC_ON;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VTC_ON: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests arriving mid-sequence are dropped and flagged
        if (busy && NATIVE_EN)
            ovr_d = 1'b1;
    end

    // State and output registers
    always_ff @(posedge REFCLK) begin
        if (REFCLK_RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            target_q <= '0;
            ramp_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            load_q   <= '0;
            vtc_q    <= '1;
            for (int k = 0; k < NUM_CH; k++)
                cur_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            target_q <= target_d;
            ramp_q   <= ramp_d;
            ovr_q    <= ovr_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            load_q   <= load_d;
            vtc_q    <= vtc_d;
            cur_q    <= cur_d;
        end
    end

    assign NATIVE_READY    = ready_q;
    assign NATIVE_DATA_OUT = rdata_q;
    assign DLY_LOAD        = load_q;
    assign DLY_EN_VTC      = vtc_q;

    // CNTVALUEIN mirrors the last loaded tap of each channel
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        assign DLY_CNTVALUEIN[k*TAP_WIDTH +: TAP_WIDTH] = cur_q[k];
    end

endmodule

// File: tb/tb_axi_delay_multi_ctrl.sv
// Randomized self-checking bench for axi_delay_multi_ctrl against a transaction-level model.
module tb_axi_delay_multi_ctrl;
    localparam int NUM_CH     = 4;
    localparam int TAP_WIDTH  = 9;
    localparam int AW         = 5;
    localparam int DW         = 9;
    localparam int VTC_SETTLE = 10;
    localparam int LOAD_GAP   = 4;
    localparam int TAP_MAX    = (1 << TAP_WIDTH) - 1;

    logic                          REFCLK = 1'b0;
    logic                          REFCLK_RESET;
    logic                          NATIVE_EN;
    logic                          NATIVE_WR;
    logic [AW-1:0]                 NATIVE_ADDR;
    logic [DW-1:0]                 NATIVE_DATA_IN;
    logic [DW-1:0]                 NATIVE_DATA_OUT;
    logic                          NATIVE_READY;
    logic                          DLY_RDY;
    logic [NUM_CH*TAP_WIDTH-1:0]   DLY_CNTVALUEIN;
    logic [NUM_CH-1:0]             DLY_LOAD;
    logic [NUM_CH-1:0]             DLY_EN_VTC;

    axi_delay_multi_ctrl #(
        .NUM_CH(NUM_CH), .TAP_WIDTH(TAP_WIDTH), .NATIVE_ADDR_WIDTH(AW),
        .NATIVE_DATA_WIDTH(DW), .VTC_SETTLE(VTC_SETTLE), .LOAD_GAP(LOAD_GAP)
    ) dut (
        .REFCLK(REFCLK), .REFCLK_RESET(REFCLK_RESET),
        .NATIVE_EN(NATIVE_EN), .NATIVE_WR(NATIVE_WR), .NATIVE_ADDR(NATIVE_ADDR),
        .NATIVE_DATA_IN(NATIVE_DATA_IN), .NATIVE_DATA_OUT(NATIVE_DATA_OUT),
        .NATIVE_READY(NATIVE_READY), .DLY_RDY(DLY_RDY),
        .DLY_CNTVALUEIN(DLY_CNTVALUEIN), .DLY_LOAD(DLY_LOAD), .DLY_EN_VTC(DLY_EN_VTC)
    );

    always #5 REFCLK = ~REFCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int cur_m [NUM_CH];
    int ramp_m;
    int ovr_m;

    // Observations from the last access
    int ld_val [$];
    int ld_cyc [$];
    int vtc_low;
    int side_bad;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) cur_m[k] = 0;
        ramp_m = 0;
        ovr_m  = 0;
    endtask

    // One native access; watches the delay outputs cycle by cycle until READY
    task automatic access(input bit wr, input int addr, input int data, input int ch,
                          input int stall_at, input int stall_len, input int ovr_at,
                          input int rst_at, input int budget,
                          output int rdata, output int rdy_cyc, output bit aborted);
        int  cyc;
        bit  rst_pend;
        @(negedge REFCLK);
        NATIVE_EN      = 1'b1;
        NATIVE_WR      = wr;
        NATIVE_ADDR    = AW'(addr);
        NATIVE_DATA_IN = DW'(data);
        ld_val.delete();
        ld_cyc.delete();
        vtc_low  = 0;
        side_bad = 0;
        rdata    = 0;
        rdy_cyc  = -1;
        aborted  = 1'b0;
        rst_pend = 1'b0;
        cyc      = 0;
        forever begin
            @(negedge REFCLK);
            cyc++;
            NATIVE_EN = 1'b0;
            DLY_RDY   = 1'b1;
            if (rst_pend) begin
                check("rst_en_vtc", int'(DLY_EN_VTC), (1 << NUM_CH) - 1);
                check("rst_load", int'(DLY_LOAD), 0);
                check("rst_cntvalue", int'(DLY_CNTVALUEIN == '0), 1);
                check("rst_ready", int'(NATIVE_READY), 0);
                REFCLK_RESET = 1'b0;
                aborted = 1'b1;
                break;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (DLY_LOAD[k]) begin
                    if (k == ch) begin
                        ld_val.push_back(int'(DLY_CNTVALUEIN[k*TAP_WIDTH +: TAP_WIDTH]));
                        ld_cyc.push_back(cyc);
                    end else side_bad++;
                end
                if (!DLY_EN_VTC[k]) begin
                    if (k != ch) side_bad++;
                    else if (ld_cyc.size() == 0) vtc_low++;
                end
            end
            if (NATIVE_READY) begin
                rdy_cyc = cyc;
                rdata   = int'(NATIVE_DATA_OUT);
                break;
            end
            if (cyc >= budget) begin
                check("ready_timeout", 0, 1);
                break;
            end
            if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) DLY_RDY = 1'b0;
            if (cyc == ovr_at) begin
                NATIVE_EN      = 1'b1;
                NATIVE_WR      = 1'b1;
                NATIVE_ADDR    = AW'(1);
                NATIVE_DATA_IN = DW'(55);
            end
            if (cyc == rst_at) begin
                REFCLK_RESET = 1'b1;
                rst_pend     = 1'b1;
            end
        end
    endtask

    // Transaction: plan expectations from the model, run it, compare, update model
    task automatic txn(input bit wr, input int addr, input int data,
                       input int stall_len, input int ovr_at, input int rst_at);
        int  exp_loads [$];
        int  ch, c, n, stall, exp_rdata, exp_rdy, t0;
        int  rdata, rdy;
        bit  ab;
        ch = (addr < NUM_CH) ? addr : -1;
        exp_rdata = 0;
        if (wr && ch >= 0 && data != cur_m[ch]) begin
            if (ramp_m != 0) begin
                c = cur_m[ch];
                while (c != data) begin
                    c = (data > c) ? c + 1 : c - 1;
                    exp_loads.push_back(c);
                end
            end else begin
                exp_loads.push_back(data);
            end
        end
        if (!wr) begin
            if (ch >= 0)            exp_rdata = cur_m[ch];
            else if (addr == NUM_CH) exp_rdata = (ovr_m << 3) | 4 | ramp_m;
        end
        n      = exp_loads.size();
        stall  = (n > 0) ? stall_len : 0;
        t0     = 2 + VTC_SETTLE + stall;
        exp_rdy = (n == 0) ? 1 : t0 + (1 + LOAD_GAP) * n;

        access(wr, addr, data, ch, 3, stall, (n > 0) ? ovr_at : -1, rst_at,
               exp_rdy + 20, rdata, rdy, ab);
        if (ab) begin
            model_reset();
            return;
        end

        check($sformatf("ready_cyc a%0d", addr), rdy, exp_rdy);
        if (!wr) check($sformatf("rdata a%0d", addr), rdata, exp_rdata);
        check("load_count", ld_val.size(), n);
        for (int i = 0; i < n && i < ld_val.size(); i++) begin
            check($sformatf("load_val%0d", i), ld_val[i], exp_loads[i]);
            check($sformatf("load_cyc%0d", i), ld_cyc[i], t0 + (1 + LOAD_GAP) * i);
        end
        if (n > 0) check("vtc_low_before_load", vtc_low, VTC_SETTLE + stall);
        check("unselected_activity", side_bad, 0);

        if (n > 0) cur_m[ch] = data;
        if (n > 0 && ovr_at > 0) ovr_m = 1;
        if (wr && addr == NUM_CH) begin
            ramp_m = data & 1;
            if (((data >> 3) & 1) != 0) ovr_m = 0;
        end
        for (int k = 0; k < NUM_CH; k++)
            check($sformatf("cntvalue_ch%0d", k),
                  int'(DLY_CNTVALUEIN[k*TAP_WIDTH +: TAP_WIDTH]), cur_m[k]);
    endtask

    initial begin
        int op, ch, v, st, ov;
        REFCLK_RESET   = 1'b1;
        NATIVE_EN      = 1'b0;
        NATIVE_WR      = 1'b0;
        NATIVE_ADDR    = '0;
        NATIVE_DATA_IN = '0;
        DLY_RDY        = 1'b1;
        model_reset();
        repeat (2) @(negedge REFCLK);
        check("init_en_vtc", int'(DLY_EN_VTC), (1 << NUM_CH) - 1);
        check("init_load", int'(DLY_LOAD), 0);
        check("init_cntvalue", int'(DLY_CNTVALUEIN == '0), 1);
        check("init_ready", int'(NATIVE_READY), 0);
        REFCLK_RESET = 1'b0;
        txn(0, NUM_CH, 0, 0, -1, -1);

        // Direct write and readback
        txn(1, 2, 100, 0, -1, -1);
        txn(0, 2, 0, 0, -1, -1);

        // Ramp up then down
        txn(1, NUM_CH, 1, 0, -1, -1);
        txn(1, 0, 5, 0, -1, -1);
        txn(1, 0, 3, 0, -1, -1);

        // Dropped request during a sequence, then clear the sticky flag
        txn(1, NUM_CH, 0, 0, -1, -1);
        txn(1, 2, 200, 0, 5, -1);
        txn(0, 1, 0, 0, -1, -1);
        txn(0, NUM_CH, 0, 0, -1, -1);
        txn(1, NUM_CH, 8, 0, -1, -1);
        txn(0, NUM_CH, 0, 0, -1, -1);

        // IDELAYCTRL not ready stretches settle; same-value write completes at once
        txn(1, 3, 77, 20, -1, -1);
        txn(1, 3, 77, 0, -1, -1);

        // Invalid addresses
        txn(1, 31, 5, 0, -1, -1);
        txn(0, NUM_CH + 1, 0, 0, -1, -1);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 5));
            ch = int'($urandom_range(0, NUM_CH - 1));
            case (op)
                0: txn(0, ch, 0, 0, -1, -1);
                1, 2: begin
                    if ($urandom_range(0, 3) == 0) v = cur_m[ch];
                    else if (ramp_m != 0) begin
                        v = cur_m[ch] + int'($urandom_range(0, 12)) - 6;
                        if (v < 0) v = 0;
                        if (v > TAP_MAX) v = TAP_MAX;
                    end else v = int'($urandom_range(0, TAP_MAX));
                    st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
                    ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 10)) : -1;
                    txn(1, ch, v, st, ov, -1);
                end
                3: txn(0, NUM_CH, 0, 0, -1, -1);
                4: txn(1, NUM_CH, int'($urandom_range(0, 15)), 0, -1, -1);
                default: txn(int'($urandom_range(0, 1)), int'($urandom_range(NUM_CH + 1, 31)),
                             int'($urandom_range(0, 511)), 0, -1, -1);
            endcase
        end

        // Reset in the middle of a ramp, right after its third step
        txn(1, NUM_CH, 1, 0, -1, -1);
        v = (cur_m[0] > TAP_MAX - 8) ? cur_m[0] - 8 : cur_m[0] + 8;
        txn(1, 0, v, 0, -1, 2 + VTC_SETTLE + 2 * (1 + LOAD_GAP));
        txn(0, 0, 0, 0, -1, -1);
        txn(0, NUM_CH, 0, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
